// File: rtl/btn_pkg.sv
// Shared definitions for the button/tick front-end: channel indices, repeat FSM states
// and a small elaboration helper.
package btn_pkg;

  localparam int BTN_TIMESET  = 0;
  localparam int BTN_ALARMSET = 1;
  localparam int BTN_MINADV   = 2;
  localparam int BTN_HRSADV   = 3;
  localparam int BTN_ALARMON  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } rpt_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchronizer, debounce, press pulse and auto-repeat.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined; otherwise adv = press.
module btn_chan
  import btn_pkg::*;
#(
  parameter int DEB_CYC  = 16,
  parameter int HOLD_CYC = 50,
  parameter int REP_CYC  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic adv
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] deb_cnt;
  logic          flip;

  // The level changes on the edge where the disagreement run would reach DEB_CYC.
  assign flip = (sync2 != level) && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb_cnt <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= flip & sync2;
      if (sync2 == level) begin
        deb_cnt <= '0;
      end else if (flip) begin
        level   <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int HW = $clog2(max_int(HOLD_CYC, REP_CYC) + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REP_CYC - 1);

  rpt_state_t    state;
  logic [HW-1:0] hold_cnt;
  logic          rpt_pulse;

  // A release seen in HOLD/RPT suppresses the pulse on that same cycle.
  assign rpt_pulse = level && (((state == HOLD) && (hold_cnt == HOLD_LAST)) ||
                               ((state == RPT)  && (hold_cnt == REP_LAST)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (!level) begin
            state <= IDLE;
          end else if (rpt_pulse) begin
            state    <= RPT;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        RPT: begin
          if (!level) begin
            state <= IDLE;
          end else if (rpt_pulse) begin
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign adv = press | rpt_pulse;
`else
  assign adv = press;
`endif

endmodule

// File: rtl/btn_tick_cond.sv
// Alarm-clock front end: NBTN conditioned button channels plus the 1/DIV Pulse tick.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses on adv.
module btn_tick_cond #(
  parameter int NBTN     = 5,
  parameter int DEB_CYC  = 16,
  parameter int HOLD_CYC = 50,
  parameter int REP_CYC  = 10,
  parameter int DIV      = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_raw,
  input  logic            tick_en,
  output logic [NBTN-1:0] level,
  output logic [NBTN-1:0] press,
  output logic [NBTN-1:0] adv,
  output logic            tick
);

  localparam int TW = $clog2(DIV);
  localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);

  logic [TW-1:0] div_cnt;

  for (genvar i = 0; i < NBTN; i++) begin : g_chan
    btn_chan #(
      .DEB_CYC (DEB_CYC),
      .HOLD_CYC(HOLD_CYC),
      .REP_CYC (REP_CYC)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw[i]),
      .level  (level[i]),
      .press  (press[i]),
      .adv    (adv[i])
    );
  end

  // Divider freezes while disabled and resumes from the held count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick_en) begin
      if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + TW'(1);
    end
  end

  assign tick = tick_en && (div_cnt == DIV_LAST);

endmodule

// File: tb/tb_btn_tick_cond.sv
// Bench for btn_tick_cond: directed scenarios plus random button/tick_en traffic checked
// against a sample-window / press-timeline reference model.
module tb_btn_tick_cond;

  localparam int NBTN     = 5;
  localparam int DEB_CYC  = 4;
  localparam int HOLD_CYC = 10;
  localparam int REP_CYC  = 3;
  localparam int DIV      = 8;
  localparam int HN       = DEB_CYC + 1;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic            clk     = 1'b0;
  logic            rst     = 1'b0;
  logic            tick_en = 1'b0;
  logic [NBTN-1:0] btn_raw = '0;
  logic [NBTN-1:0] level;
  logic [NBTN-1:0] press;
  logic [NBTN-1:0] adv;
  logic            tick;
  int n_cmp  = 0;
  int n_fail = 0;

  btn_tick_cond #(
    .NBTN(NBTN), .DEB_CYC(DEB_CYC), .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC), .DIV(DIV)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .tick_en(tick_en),
    .level(level), .press(press), .adv(adv), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: rh[k] holds btn_raw as sampled k+1 edges ago. The debounced level
  // toggles when the DEB_CYC samples seen by the second sync stage all disagree with it.
  logic [HN-1:0][NBTN-1:0] rh;
  logic [NBTN-1:0] m_level, m_press, m_flip;
  int m_cyc, m_en;
  int m_pcyc [NBTN];

  function automatic logic [NBTN-1:0] flips(input logic [HN-1:0][NBTN-1:0] h,
                                            input logic [NBTN-1:0] lv);
    logic [NBTN-1:0] f;
    f = '1;
    for (int c = 0; c < NBTN; c++)
      for (int k = 1; k <= DEB_CYC; k++)
        if (h[k][c] == lv[c]) f[c] = 1'b0;
    return f;
  endfunction

  assign m_flip = flips(rh, m_level);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rh      <= '0;
      m_level <= '0;
      m_press <= '0;
      m_cyc   <= 0;
      m_en    <= 0;
      for (int c = 0; c < NBTN; c++) m_pcyc[c] <= -1;
    end else begin
      rh      <= {rh[HN-2:0], btn_raw};
      m_level <= m_level ^ m_flip;
      m_press <= m_flip & ~m_level;
      m_cyc   <= m_cyc + 1;
      if (tick_en) m_en <= m_en + 1;
      for (int c = 0; c < NBTN; c++)
        if (m_flip[c] && !m_level[c]) m_pcyc[c] <= m_cyc + 1;
        else if (m_flip[c])           m_pcyc[c] <= -1;
    end
  end

  // Repeats land at press + HOLD_CYC + n*REP_CYC while the level stays high.
  function automatic logic [NBTN-1:0] m_rpt();
    logic [NBTN-1:0] r;
    r = '0;
    for (int c = 0; c < NBTN; c++) begin
      int rel;
      rel = m_cyc - m_pcyc[c];
      if (AR && m_level[c] && m_pcyc[c] >= 0 && rel >= HOLD_CYC &&
          ((rel - HOLD_CYC) % REP_CYC) == 0) r[c] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [3*NBTN:0] exp_out();
    return {m_level, m_press, m_press | m_rpt(), tick_en && ((m_en % DIV) == DIV - 1)};
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int first;
    rst = 1'b0; btn_raw = '0; tick_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({level, press, adv, tick} !== '0) begin
        n_fail++;
        $display("FAIL reset_state got=%b want=0", {level, press, adv, tick});
      end
    end
    rst = 1'b1;
    first = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({level, press, adv, tick} !== exp_out()) begin
        n_fail++;
        $display("FAIL idle_model k=%0d got=%b want=%b", k, {level, press, adv, tick}, exp_out());
      end
      if (tick && first == 0) first = k;
    end
    // Cycle numbering counts the cycle in which rst rises as cycle 1.
    n_cmp++;
    if (first + 1 != DIV) begin
      n_fail++;
      $display("FAIL first_tick got cycle %0d want cycle %0d", first + 1, DIV);
    end
  endtask

  task automatic test_clean_press();
    idle_cycles($urandom_range(1, 7));
    btn_raw[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({level, press, adv, tick} !== exp_out()) begin
        n_fail++;
        $display("FAIL press_model k=%0d got=%b want=%b", k, {level, press, adv, tick}, exp_out());
      end
      n_cmp++;
      if ({level[2], press[2], adv[2]} !== {k >= DEB_CYC + 1, k == DEB_CYC + 1, k == DEB_CYC + 1}) begin
        n_fail++;
        $display("FAIL press_timing k=%0d got lvl/prs/adv=%b%b%b", k, level[2], press[2], adv[2]);
      end
    end
    btn_raw[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({level, press, adv, tick} !== exp_out() || press[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL release k=%0d got=%b want=%b", k, {level, press, adv, tick}, exp_out());
      end
    end
  endtask

  task automatic test_glitch();
    int len;
    idle_cycles(4);
    len = $urandom_range(1, DEB_CYC - 1);
    btn_raw[3] = 1'b1;
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({level[3], press[3], adv[3], level[0], press[0], adv[0]} !== '0 ||
          {level, press, adv, tick} !== exp_out()) begin
        n_fail++;
        $display("FAIL glitch k=%0d got=%b want=%b", k, {level, press, adv, tick}, exp_out());
      end
      if (k == 2) btn_raw[3] = 1'b0;
      if (k == len - 1) btn_raw[0] = 1'b0;
    end
  endtask

  task automatic test_autorepeat();
    int p;
    logic want;
    p = -1;
    btn_raw[2] = 1'b1;
    for (int k = 0; k < 52; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({level, press, adv, tick} !== exp_out()) begin
        n_fail++;
        $display("FAIL repeat_model k=%0d got=%b want=%b", k, {level, press, adv, tick}, exp_out());
      end
      if (press[2] && p < 0) p = k;
      if (p >= 0 && k - p < 30) begin
        want = (k == p) || (AR && (k - p) >= HOLD_CYC && ((k - p - HOLD_CYC) % REP_CYC) == 0);
        n_cmp++;
        if (adv[2] !== want) begin
          n_fail++;
          $display("FAIL repeat_adv rel=%0d got=%b want=%b", k - p, adv[2], want);
        end
      end
      if (p >= 0 && k >= p + 30 + DEB_CYC + 2) begin
        n_cmp++;
        if ({level[2], adv[2]} !== 2'b00) begin
          n_fail++;
          $display("FAIL repeat_stop k=%0d got lvl/adv=%b%b want 00", k, level[2], adv[2]);
        end
      end
      if (p >= 0 && k == p + 30) btn_raw[2] = 1'b0;
    end
    n_cmp++;
    if (p != DEB_CYC + 1) begin
      n_fail++;
      $display("FAIL repeat_press_at got=%0d want=%0d", p, DEB_CYC + 1);
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    btn_raw[3:2] = 2'b11;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      n_cmp++;
      if (press[2] !== press[3] || press[2] !== (k == DEB_CYC + 1) ||
          {level, press, adv, tick} !== exp_out()) begin
        n_fail++;
        $display("FAIL simul k=%0d got=%b want=%b", k, {level, press, adv, tick}, exp_out());
      end
    end
    btn_raw = '0;
    found = 1'b0;
    for (int w = 0; w < 2 * DIV; w++) begin
      @(negedge clk);
      if ((m_en % DIV) == 5) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL tick_count5_timeout got=none want=count 5");
    end
    tick_en = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      n_cmp++;
      if (tick !== 1'b0 || {level, press, adv, tick} !== exp_out()) begin
        n_fail++;
        $display("FAIL tick_frozen j=%0d got=%b want=0", j, tick);
      end
    end
    tick_en = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      n_cmp++;
      if (tick !== (j == 2) || {level, press, adv, tick} !== exp_out()) begin
        n_fail++;
        $display("FAIL tick_resume j=%0d got=%b want=%b", j, tick, j == 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    int p;
    bit reached;
    p = -1;
    reached = 1'b0;
    idle_cycles(8);
    btn_raw[2] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({level, press, adv, tick} !== exp_out()) begin
        n_fail++;
        $display("FAIL pre_reset k=%0d got=%b want=%b", k, {level, press, adv, tick}, exp_out());
      end
      if (press[2] && p < 0) p = k;
      if (p >= 0 && k == p + HOLD_CYC + 1) begin
        reached = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!reached) begin
      n_fail++;
      $display("FAIL reach_repeat_timeout got p=%0d want press seen", p);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({level, press, adv, tick} !== '0) begin
      n_fail++;
      $display("FAIL async_clear got=%b want=0", {level, press, adv, tick});
    end
    @(negedge clk);
    n_cmp++;
    if ({level, press, adv, tick} !== '0) begin
      n_fail++;
      $display("FAIL held_reset got=%b want=0", {level, press, adv, tick});
    end
    rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_cmp++;
      if (press[2] !== (k == DEB_CYC + 2) || level[2] !== (k >= DEB_CYC + 2) ||
          {level, press, adv, tick} !== exp_out()) begin
        n_fail++;
        $display("FAIL repress k=%0d got=%b want=%b", k, {level, press, adv, tick}, exp_out());
      end
    end
    btn_raw = '0;
    idle_cycles(10);
  endtask

  task automatic test_random();
    logic [NBTN-1:0] prev_adv;
    prev_adv = '0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({level, press, adv, tick} !== exp_out() || (prev_adv & adv) !== '0) begin
        n_fail++;
        $display("FAIL random k=%0d got=%b want=%b", k, {level, press, adv, tick}, exp_out());
      end
      prev_adv = adv;
      for (int c = 0; c < NBTN; c++)
        if ($urandom_range(0, 5 + 4 * c) == 0) btn_raw[c] = ~btn_raw[c];
      tick_en = ($urandom_range(0, 9) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_autorepeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
